// File: rtl/bcd_key_entry_pkg.sv
// Shared definitions for the keypad operand entry block: default key codes,
// FSM state encoding and a digit-range helper.
package bcd_key_entry_pkg;

   localparam logic [3:0] DEF_KEY_POINT = 4'hA;
   localparam logic [3:0] DEF_KEY_CLEAR = 4'hB;
   localparam logic [3:0] DEF_KEY_ENTER = 4'hC;
   localparam logic [3:0] DIGIT_MAX     = 4'd9;

   typedef enum logic [1:0] {
      ST_INT  = 2'd0,
      ST_FRAC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= DIGIT_MAX;
   endfunction

endpackage

// File: rtl/bcd_key_entry_if.sv
// Keypad strobe in, assembled BCD operand and status out.
// master = keypad/datapath side, slave = the entry block.
interface bcd_key_entry_if #(
   parameter int INT_DIGITS = 2
);
   logic                    key_valid;
   logic [3:0]              key_code;
   logic [4*INT_DIGITS-1:0] int_bcd;
   logic [3:0]              frac_bcd;
   logic                    has_point;
   logic [2:0]              int_count;
   logic                    ovf;
   logic                    entry_done;
   logic                    done_pulse;

   modport master (
      output key_valid, key_code,
      input  int_bcd, frac_bcd, has_point, int_count, ovf, entry_done, done_pulse
   );

   modport slave (
      input  key_valid, key_code,
      output int_bcd, frac_bcd, has_point, int_count, ovf, entry_done, done_pulse
   );
endinterface

// File: rtl/bcd_key_entry_shift_field.sv
// Nibble shift register holding up to DIGITS BCD digits with a saturating
// count. clear and load together restart the field with a single digit.
module bcd_shift_field #(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                load,
   input  logic [3:0]          digit,
   output logic [4*DIGITS-1:0] field,
   output logic [2:0]          count,
   output logic                full
);

   assign full = (count == 3'(DIGITS));

   // Shift in at the low nibble so the first digit entered ends up most significant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         field <= '0;
         count <= '0;
      end else if (clear) begin
         if (load) begin
            field <= (4*DIGITS)'(digit);
            count <= 3'd1;
         end else begin
            field <= '0;
            count <= '0;
         end
      end else if (load && !full) begin
         field <= (field << 4) | (4*DIGITS)'(digit);
         count <= count + 3'd1;
      end
   end

endmodule

// File: rtl/bcd_key_entry.sv
// Keypad operand capture: integer BCD digits, one fractional digit, and a
// completion level/pulse for the calculator datapath.
module bcd_key_entry
   import bcd_key_entry_pkg::*;
#(
   parameter int         INT_DIGITS = 2,
   parameter logic [3:0] KEY_POINT  = DEF_KEY_POINT,
   parameter logic [3:0] KEY_CLEAR  = DEF_KEY_CLEAR,
   parameter logic [3:0] KEY_ENTER  = DEF_KEY_ENTER
) (
   input  logic           clk,
   input  logic           rst,
   bcd_key_entry_if.slave bus
);

   state_t     state_q, state_next;
   logic [3:0] frac_q, frac_next;
   logic       frac_taken_q, frac_taken_next;
   logic       has_point_q, has_point_next;
   logic       ovf_q, ovf_next;
   logic       pulse_q, pulse_next;
   logic       shift_clear, shift_load, field_full;

   logic key_point, key_clear, key_enter, key_digit;

   // Control keys take precedence so a remapped code never doubles as a digit.
   assign key_point = bus.key_valid && (bus.key_code == KEY_POINT);
   assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
   assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
   assign key_digit = bus.key_valid && is_digit(bus.key_code)
                      && !(bus.key_code == KEY_POINT)
                      && !(bus.key_code == KEY_CLEAR)
                      && !(bus.key_code == KEY_ENTER);

   bcd_shift_field #(
      .DIGITS (INT_DIGITS)
   ) u_int_field (
      .clk   (clk),
      .rst   (rst),
      .clear (shift_clear),
      .load  (shift_load),
      .digit (bus.key_code),
      .field (bus.int_bcd),
      .count (bus.int_count),
      .full  (field_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_INT;
         frac_q       <= '0;
         frac_taken_q <= 1'b0;
         has_point_q  <= 1'b0;
         ovf_q        <= 1'b0;
         pulse_q      <= 1'b0;
      end else begin
         state_q      <= state_next;
         frac_q       <= frac_next;
         frac_taken_q <= frac_taken_next;
         has_point_q  <= has_point_next;
         ovf_q        <= ovf_next;
         pulse_q      <= pulse_next;
      end
   end

   always_comb begin
      state_next      = state_q;
      frac_next       = frac_q;
      frac_taken_next = frac_taken_q;
      has_point_next  = has_point_q;
      ovf_next        = ovf_q;
      pulse_next      = 1'b0;
      shift_clear     = 1'b0;
      shift_load      = 1'b0;

      if (key_clear) begin
         state_next      = ST_INT;
         frac_next       = '0;
         frac_taken_next = 1'b0;
         has_point_next  = 1'b0;
         ovf_next        = 1'b0;
         shift_clear     = 1'b1;
      end else begin
         case (state_q)
            ST_INT: begin
               if (key_digit) begin
                  if (field_full) ovf_next = 1'b1;
                  else            shift_load = 1'b1;
               end else if (key_point) begin
                  has_point_next = 1'b1;
                  state_next     = ST_FRAC;
               end else if (key_enter) begin
                  state_next = ST_DONE;
                  pulse_next = 1'b1;
               end
            end
            ST_FRAC: begin
               if (key_digit) begin
                  if (frac_taken_q) begin
                     ovf_next = 1'b1;
                  end else begin
                     frac_next       = bus.key_code;
                     frac_taken_next = 1'b1;
                  end
               end else if (key_enter) begin
                  state_next = ST_DONE;
                  pulse_next = 1'b1;
               end
            end
            ST_DONE: begin
               // A digit after completion starts the next operand in one step.
               if (key_digit) begin
                  state_next      = ST_INT;
                  frac_next       = '0;
                  frac_taken_next = 1'b0;
                  has_point_next  = 1'b0;
                  ovf_next        = 1'b0;
                  shift_clear     = 1'b1;
                  shift_load      = 1'b1;
               end
            end
            default: state_next = ST_INT;
         endcase
      end
   end

   assign bus.frac_bcd   = frac_q;
   assign bus.has_point  = has_point_q;
   assign bus.ovf        = ovf_q;
   assign bus.entry_done = (state_q == ST_DONE);
   assign bus.done_pulse = pulse_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Scoreboard bench for bcd_key_entry with INT_DIGITS = 2: stimulus pushes
// hand-computed expectations, a monitor pops and compares each response.
module tb_bcd_key_entry;

   typedef struct packed {
      logic [7:0] int_bcd;
      logic [3:0] frac_bcd;
      logic       has_point;
      logic [2:0] int_count;
      logic       ovf;
      logic       entry_done;
      logic       done_pulse;
   } exp_t;

   logic clk;
   logic rst;
   logic chk_strobe;
   logic armed;

   int vectors;
   int miscompares;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  mon_e;
   string mon_n;

   bcd_key_entry_if #(.INT_DIGITS(2)) bus ();

   bcd_key_entry #(
      .INT_DIGITS (2),
      .KEY_POINT  (4'hA),
      .KEY_CLEAR  (4'hB),
      .KEY_ENTER  (4'hC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] ib, input logic [3:0] fb, input logic hp,
                               input logic [2:0] cnt, input logic ov, input logic dn,
                               input logic pl);
      exp_t e;
      e.int_bcd    = ib;
      e.frac_bcd   = fb;
      e.has_point  = hp;
      e.int_count  = cnt;
      e.ovf        = ov;
      e.entry_done = dn;
      e.done_pulse = pl;
      return e;
   endfunction

   task automatic checkOutput(input string name, input exp_t e);
      exp_t act;
      act.int_bcd    = bus.int_bcd;
      act.frac_bcd   = bus.frac_bcd;
      act.has_point  = bus.has_point;
      act.int_count  = bus.int_count;
      act.ovf        = bus.ovf;
      act.entry_done = bus.entry_done;
      act.done_pulse = bus.done_pulse;
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("[TB] FAIL %s: got int=%h frac=%h pt=%b cnt=%0d ovf=%b done=%b pulse=%b, expected int=%h frac=%h pt=%b cnt=%0d ovf=%b done=%b pulse=%b",
                  name, act.int_bcd, act.frac_bcd, act.has_point, act.int_count, act.ovf,
                  act.entry_done, act.done_pulse, e.int_bcd, e.frac_bcd, e.has_point,
                  e.int_count, e.ovf, e.entry_done, e.done_pulse);
      end
   endtask

   always @(posedge clk) armed <= chk_strobe;

   always @(negedge clk) begin
      if (armed) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checkOutput(mon_n, mon_e);
         end
      end
   end

   task automatic applyStimulus(input string name, input logic v, input logic [3:0] code,
                                input exp_t e);
      @(posedge clk);
      #1;
      bus.key_valid = v;
      bus.key_code  = code;
      chk_strobe    = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   task automatic endStimulus();
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      chk_strobe    = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 20) begin
         @(negedge clk);
         #1;
         i++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s_drain: got %0d pending, expected 0", name, exp_q.size());
         exp_q.delete();
         name_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors       = 0;
      miscompares   = 0;
      armed         = 1'b0;
      chk_strobe    = 1'b0;
      rst           = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;

      applyStimulus("reset_state", 1'b0, 4'h0, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));

      // 4, 7, ENTER, then the pulse must drop
      applyStimulus("t1_d4",    1'b1, 4'h4, mk(8'h04, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t1_d7",    1'b1, 4'h7, mk(8'h47, 4'h0, 0, 3'd2, 0, 0, 0));
      applyStimulus("t1_enter", 1'b1, 4'hC, mk(8'h47, 4'h0, 0, 3'd2, 0, 1, 1));
      applyStimulus("t1_idle",  1'b0, 4'h0, mk(8'h47, 4'h0, 0, 3'd2, 0, 1, 0));
      applyStimulus("t4_enter_again", 1'b1, 4'hC, mk(8'h47, 4'h0, 0, 3'd2, 0, 1, 0));
      applyStimulus("t4_point_done",  1'b1, 4'hA, mk(8'h47, 4'h0, 0, 3'd2, 0, 1, 0));
      applyStimulus("t4_code_e_done", 1'b1, 4'hE, mk(8'h47, 4'h0, 0, 3'd2, 0, 1, 0));
      applyStimulus("t4_new_entry",   1'b1, 4'h2, mk(8'h02, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t4_clear",       1'b1, 4'hB, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));

      // 3 . 5 ENTER
      applyStimulus("t2_d3",    1'b1, 4'h3, mk(8'h03, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t2_point", 1'b1, 4'hA, mk(8'h03, 4'h0, 1, 3'd1, 0, 0, 0));
      applyStimulus("t2_d5",    1'b1, 4'h5, mk(8'h03, 4'h5, 1, 3'd1, 0, 0, 0));
      applyStimulus("t2_enter", 1'b1, 4'hC, mk(8'h03, 4'h5, 1, 3'd1, 0, 1, 1));
      applyStimulus("t2_idle",  1'b0, 4'h0, mk(8'h03, 4'h5, 1, 3'd1, 0, 1, 0));
      applyStimulus("t2_clear", 1'b1, 4'hB, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));

      // integer overflow, then fractional overflow
      applyStimulus("t3_d1",       1'b1, 4'h1, mk(8'h01, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t3_novalid",  1'b0, 4'h3, mk(8'h01, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t3_d2",       1'b1, 4'h2, mk(8'h12, 4'h0, 0, 3'd2, 0, 0, 0));
      applyStimulus("t3_d9_ovf",   1'b1, 4'h9, mk(8'h12, 4'h0, 0, 3'd2, 1, 0, 0));
      applyStimulus("t3_point",    1'b1, 4'hA, mk(8'h12, 4'h0, 1, 3'd2, 1, 0, 0));
      applyStimulus("t3_d8",       1'b1, 4'h8, mk(8'h12, 4'h8, 1, 3'd2, 1, 0, 0));
      applyStimulus("t3_d6_ovf",   1'b1, 4'h6, mk(8'h12, 4'h8, 1, 3'd2, 1, 0, 0));
      applyStimulus("t3_point2",   1'b1, 4'hA, mk(8'h12, 4'h8, 1, 3'd2, 1, 0, 0));
      applyStimulus("t3_code_e",   1'b1, 4'hE, mk(8'h12, 4'h8, 1, 3'd2, 1, 0, 0));
      applyStimulus("t3_enter",    1'b1, 4'hC, mk(8'h12, 4'h8, 1, 3'd2, 1, 1, 1));
      applyStimulus("t3_restart",  1'b1, 4'h7, mk(8'h07, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t3_clear",    1'b1, 4'hB, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));

      // clear from FRAC, ignored code, empty entry
      applyStimulus("t5_d5",       1'b1, 4'h5, mk(8'h05, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t5_point",    1'b1, 4'hA, mk(8'h05, 4'h0, 1, 3'd1, 0, 0, 0));
      applyStimulus("t5_clear",    1'b1, 4'hB, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));
      applyStimulus("t5_code_e",   1'b1, 4'hE, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));
      applyStimulus("t5_d0",       1'b1, 4'h0, mk(8'h00, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t5_clear2",   1'b1, 4'hB, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));
      applyStimulus("t5_empty_enter", 1'b1, 4'hC, mk(8'h00, 4'h0, 0, 3'd0, 0, 1, 1));
      applyStimulus("t5_idle",     1'b0, 4'h0, mk(8'h00, 4'h0, 0, 3'd0, 0, 1, 0));
      applyStimulus("t5_clear3",   1'b1, 4'hB, mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));

      // asynchronous reset mid-entry
      applyStimulus("t6_d0",       1'b1, 4'h0, mk(8'h00, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t6_d9",       1'b1, 4'h9, mk(8'h09, 4'h0, 0, 3'd2, 0, 0, 0));
      applyStimulus("t6_hold",     1'b0, 4'h0, mk(8'h09, 4'h0, 0, 3'd2, 0, 0, 0));
      endStimulus();
      waitDrain("t6");

      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_rst", mk(8'h00, 4'h0, 0, 3'd0, 0, 0, 0));
      @(negedge clk);
      #1;
      rst = 1'b0;

      applyStimulus("t6_d6_after", 1'b1, 4'h6, mk(8'h06, 4'h0, 0, 3'd1, 0, 0, 0));
      applyStimulus("t6_idle",     1'b0, 4'h0, mk(8'h06, 4'h0, 0, 3'd1, 0, 0, 0));
      endStimulus();
      waitDrain("final");
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
